// File: rtl/esp_bridge_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the ESP32 UART-to-Wishbone bridge.
package esp_bridge_pkg;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ST_OK  = 8'h06;
    localparam logic [7:0] ST_ERR = 8'h15;
    localparam logic [7:0] ST_TMO = 8'h18;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = word[31:24];
            2'd1:    word_byte = word[23:16];
            2'd2:    word_byte = word[15:8];
            default: word_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/esp_timeout_ctr.sv
// Saturating cycle counter; expired_o is high while enabled on the MAX-th counted cycle onward.
module esp_timeout_ctr #(
    parameter int MAX = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_q;

    // Count enabled cycles, holding at the terminal value until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else if (clr_i) begin
            count_q <= {W{1'b0}};
        end else if (en_i && (count_q != LAST)) begin
            count_q <= count_q + W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/esp_uart_wb_master.sv
// ESP32 command-frame parser that issues single Wishbone classic transfers and
// reports status (and read data) back over the UART TX byte stream.
module esp_uart_wb_master
    import esp_bridge_pkg::*;
#(
    parameter int RX_TIMEOUT  = 5_000_000,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        drop_o
);
    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  cnt_q;
    logic        is_wr_q;
    logic        rd_ok_q;
    logic        data_phase_q;
    logic        cyc_q;
    logic        we_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        drop_q;
    logic        rx_expired_s;
    logic        bus_expired_s;

    esp_timeout_ctr #(.MAX(RX_TIMEOUT)) u_rx_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     ((state_q == S_IDLE) || rx_valid_i),
        .en_i      ((state_q == S_ADDR) || (state_q == S_DATA)),
        .expired_o (rx_expired_s)
    );

    esp_timeout_ctr #(.MAX(BUS_TIMEOUT)) u_bus_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != S_BUS),
        .en_i      (state_q == S_BUS),
        .expired_o (bus_expired_s)
    );

    // Frame parsing, bus transfer and response sequencing with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            cnt_q        <= 2'd0;
            is_wr_q      <= 1'b0;
            rd_ok_q      <= 1'b0;
            data_phase_q <= 1'b0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            drop_q       <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i && ((rx_data_i == CMD_WR) || (rx_data_i == CMD_RD))) begin
                        is_wr_q <= (rx_data_i == CMD_WR);
                        cnt_q   <= 2'd0;
                        state_q <= S_ADDR;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADDR, S_DATA: begin
                    // A byte arriving on the expiry cycle is lost together with the frame.
                    if (rx_expired_s) begin
                        drop_q  <= rx_valid_i;
                        cnt_q   <= 2'd0;
                        state_q <= S_IDLE;
                    end else if (rx_valid_i) begin
                        if (state_q == S_ADDR) begin
                            addr_q <= {addr_q[23:0], rx_data_i};
                        end else begin
                            wdata_q <= {wdata_q[23:0], rx_data_i};
                        end
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if ((state_q == S_ADDR) && is_wr_q) begin
                                state_q <= S_DATA;
                            end else begin
                                cyc_q   <= 1'b1;
                                we_q    <= is_wr_q;
                                state_q <= S_BUS;
                            end
                        end
                    end
                end
                S_BUS: begin
                    drop_q <= rx_valid_i;
                    if (wb_err_i || wb_ack_i || bus_expired_s) begin
                        cyc_q        <= 1'b0;
                        we_q         <= 1'b0;
                        tx_valid_q   <= 1'b1;
                        data_phase_q <= 1'b0;
                        cnt_q        <= 2'd0;
                        state_q      <= S_RESP;
                        if (wb_err_i) begin
                            tx_data_q <= ST_ERR;
                            rd_ok_q   <= 1'b0;
                        end else if (wb_ack_i) begin
                            tx_data_q <= ST_OK;
                            rd_ok_q   <= !is_wr_q;
                            if (!is_wr_q) begin
                                rdata_q <= wb_dat_i;
                            end
                        end else begin
                            tx_data_q <= ST_TMO;
                            rd_ok_q   <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    drop_q <= rx_valid_i;
                    if (tx_valid_q && tx_ready_i) begin
                        if (!data_phase_q && rd_ok_q) begin
                            data_phase_q <= 1'b1;
                            cnt_q        <= 2'd0;
                            tx_data_q    <= word_byte(rdata_q, 2'd0);
                        end else if (data_phase_q && (cnt_q != 2'd3)) begin
                            cnt_q     <= cnt_q + 2'd1;
                            tx_data_q <= word_byte(rdata_q, cnt_q + 2'd1);
                        end else begin
                            tx_valid_q   <= 1'b0;
                            data_phase_q <= 1'b0;
                            rd_ok_q      <= 1'b0;
                            cnt_q        <= 2'd0;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    cyc_q      <= 1'b0;
                    we_q       <= 1'b0;
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_adr_o   = addr_q;
    assign wb_dat_o   = wdata_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = 4'hF;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign drop_o     = drop_q;

endmodule

// File: tb/tb_esp_uart_wb_master.sv
// Directed plus randomized bench for the UART-to-Wishbone bridge, checked against a frame-level reply model.
module tb_esp_uart_wb_master;

    typedef logic [7:0] byte_q_t[$];

    localparam int OUT_ACK  = 0;
    localparam int OUT_ERR  = 1;
    localparam int OUT_BOTH = 2;
    localparam int OUT_NONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        busy;
    logic        drop;

    int vectors = 0;
    int miscompares = 0;

    esp_uart_wb_master #(.RX_TIMEOUT(100), .BUS_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we),
        .wb_sel_o   (wb_sel),
        .wb_stb_o   (wb_stb),
        .wb_cyc_o   (wb_cyc),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err),
        .busy_o     (busy),
        .drop_o     (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reply the ESP32 should see for one frame, from the status rules alone.
    function automatic byte_q_t expected_reply(input bit is_wr, input int outcome, input logic [31:0] rdata);
        byte_q_t q;
        q = {};
        if (outcome == OUT_NONE) q.push_back(8'h18);
        else if (outcome != OUT_ACK) q.push_back(8'h15);
        else begin
            q.push_back(8'h06);
            if (!is_wr)
                for (int i = 0; i < 4; i++) q.push_back(8'((rdata >> (24 - 8 * i)) & 32'hFF));
        end
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] bytes[$];
        bytes = {};
        bytes.push_back(is_wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) bytes.push_back(8'(addr >> (24 - 8 * i)));
        if (is_wr) for (int i = 0; i < 4; i++) bytes.push_back(8'(wdata >> (24 - 8 * i)));
        foreach (bytes[i]) begin
            if (i != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(bytes[i]);
        end
    endtask

    task automatic collect_reply(input byte_q_t exp_q, input int stall);
        byte_q_t got_q;
        logic [7:0] held;
        int t = 0;
        int unstable = 0;
        bit held_set = 1'b0;
        got_q = {};
        while (got_q.size() < exp_q.size() && t < 400) begin
            if (tx_valid === 1'b1) begin
                if (stall > 0) begin
                    tx_ready = 1'b0;
                    if (!held_set) begin held = tx_data; held_set = 1'b1; end
                    else if (tx_data !== held) unstable++;
                    stall--;
                end else begin
                    tx_ready = 1'b1;
                    got_q.push_back(tx_data);
                end
            end else tx_ready = 1'b0;
            @(negedge clk);
            t++;
        end
        tx_ready = 1'b0;
        check("reply_len", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size(); i++) check($sformatf("reply_byte%0d", i), got_q[i], exp_q[i]);
        if (held_set) check("tx_hold_stable", unstable, 0);
        check("tx_idle_after", tx_valid, 1'b0);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int outcome, input int lat,
                          input bit inject, input int stall);
        int cyc_cnt = 0;
        int stb_bad = 0;
        send_frame(is_wr, addr, wdata);
        check("cyc_latency", wb_cyc, 1'b1);
        check("adr", wb_adr, addr);
        if (is_wr) check("wdat", wb_dat_o, wdata);
        check("we", wb_we, is_wr);
        check("sel", wb_sel, 4'hF);
        if (outcome == OUT_NONE) begin
            int t = 0;
            while (wb_cyc === 1'b1 && t < 100) begin
                cyc_cnt++;
                if (wb_stb !== wb_cyc || wb_adr !== addr) stb_bad++;
                @(negedge clk);
                t++;
            end
            check("tmo_cyc_len", cyc_cnt, 16);
            wb_ack   = 1'b1;
            wb_dat_i = $urandom;
            @(negedge clk);
            wb_ack = 1'b0;
            check("late_ack_no_cyc", wb_cyc, 1'b0);
        end else begin
            for (int k = 0; k <= lat; k++) begin
                if (wb_cyc === 1'b1) cyc_cnt++;
                if (wb_stb !== wb_cyc || wb_adr !== addr) stb_bad++;
                wb_dat_i = (k == lat) ? rdata : $urandom;
                if (k == lat) begin
                    wb_ack = (outcome != OUT_ERR);
                    wb_err = (outcome != OUT_ACK);
                end
                if (inject && k == 0 && lat >= 1) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'($urandom);
                end
                @(negedge clk);
                wb_ack = 1'b0;
                wb_err = 1'b0;
                wb_dat_i = $urandom;
                if (rx_valid) begin
                    rx_valid = 1'b0;
                    check("drop_pulse", drop, 1'b1);
                end
            end
            check("cyc_len", cyc_cnt, lat + 1);
            check("cyc_released", wb_cyc, 1'b0);
            check("tx_latency", tx_valid, 1'b1);
        end
        check("stb_eq_cyc", stb_bad, 0);
        collect_reply(expected_reply(is_wr, outcome, rdata), stall);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_sel", wb_sel, 4'hF);
        check("rst_adr", wb_adr, 32'h0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed write, then the directed read with a 3-cycle slave.
        do_txn(1'b1, 32'h0000_1000, 32'h0000_0001, 32'h0, OUT_ACK, 1, 1'b0, 0);
        do_txn(1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, OUT_ACK, 3, 1'b0, 0);
        do_txn(1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, OUT_ERR, 2, 1'b0, 0);
        do_txn(1'b0, 32'h0000_2004, 32'h0, 32'h1234_5678, OUT_BOTH, 1, 1'b0, 0);
        do_txn(1'b0, 32'h0000_3000, 32'h0, 32'h0, OUT_NONE, 0, 1'b0, 0);
        do_txn(1'b0, 32'hCAFE_0010, 32'h0, 32'hA5C3_0F96, OUT_ACK, 2, 1'b1, 20);

        // Junk command byte is ignored without a drop.
        send_byte(8'hFF);
        check("junk_no_drop", drop, 1'b0);
        check("junk_not_busy", busy, 1'b0);

        // Partial frame abandoned by the inter-byte timer.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        seen = 0;
        repeat (150) begin
            if (wb_cyc === 1'b1 || tx_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("rxtmo_no_activity", seen, 0);
        check("rxtmo_idle", busy, 1'b0);
        do_txn(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, OUT_ACK, 1, 1'b0, 0);

        // Randomized frames against the reply model.
        for (int n = 0; n < 8; n++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a bus cycle.
        send_frame(1'b0, 32'h0000_5000, 32'h0);
        check("pre_rst_cyc", wb_cyc, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cyc", wb_cyc, 1'b0);
        check("midrst_stb", wb_stb, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (tx_valid === 1'b1 || wb_cyc === 1'b1) seen++;
            @(negedge clk);
        end
        check("midrst_no_resp", seen, 0);
        do_txn(1'b1, 32'h0000_0080, 32'h7788_99AA, 32'h0, OUT_ACK, 0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
